// File: rtl/estagio_acesso_memoria.sv
// estagio_acesso_memoria: MEM-stage controller in front of Memoria_de_Dados.
// Takes one load/store/passthrough per handshake from execute, holds a memory
// access for LATENCIA cycles, and retires every operation to write-back as a
// single-cycle wb_valido pulse.
// Optional feature: define MEM_BYPASS_EN to let a load that hits the last
// retired store complete in one cycle without touching memory.
module estagio_acesso_memoria #(
  parameter int LARGURA_DADO = 8,
  parameter int LARGURA_END  = 8,
  parameter int LARGURA_REG  = 3,
  parameter int LATENCIA     = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ex_valido,
  output logic                    ex_pronto,
  input  logic                    ex_LerMem,
  input  logic                    ex_EscMem,
  input  logic [LARGURA_END-1:0]  ex_endereco,
  input  logic [LARGURA_DADO-1:0] ex_dado,
  input  logic [LARGURA_REG-1:0]  ex_rd,
  output logic [LARGURA_END-1:0]  Endereco_mem,
  output logic [LARGURA_DADO-1:0] DadoEscr,
  output logic                    EscMem,
  output logic                    LerMem,
  input  logic [LARGURA_DADO-1:0] DadoLido,
  output logic                    wb_valido,
  output logic [LARGURA_DADO-1:0] wb_dado,
  output logic [LARGURA_REG-1:0]  wb_rd,
  output logic                    wb_EscReg
);

  // Counter only needs to reach LATENCIA-1; keep at least one bit.
  localparam int LARG_CONT = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
  localparam logic [LARG_CONT-1:0] CONT_INI = LARG_CONT'(LATENCIA - 1);

  localparam logic [0:0] OCIOSO = 1'b0;
  localparam logic [0:0] ACESSO = 1'b1;

  logic [0:0]              estado;
  logic [LARG_CONT-1:0]    cont;
  logic [LARGURA_END-1:0]  end_r;
  logic [LARGURA_DADO-1:0] dado_r;
  logic [LARGURA_REG-1:0]  rd_r;
  logic                    op_esc;   // latched op: 1 = store, 0 = load

  logic                    aceita;
  logic                    eh_esc;
  logic                    eh_ler;
  logic                    acerto;   // load served from the last-store record
  logic                    passa;    // operation retires on the accept edge
  logic                    fim;      // final ACESSO cycle
  logic [LARGURA_DADO-1:0] dado_passa;

  assign ex_pronto = (estado == OCIOSO) & ~reset;
  assign aceita    = ex_valido & ex_pronto;
  // Both flags set is illegal; write wins.
  assign eh_esc    = ex_EscMem;
  assign eh_ler    = ex_LerMem & ~ex_EscMem;
  assign passa     = ~eh_esc & (~eh_ler | acerto);
  assign fim       = (estado == ACESSO) && (cont == '0);

  // Memory strobes are combinational so that reset drops them immediately;
  // a store only writes in its last cycle, so an aborted store never writes.
  assign LerMem       = (estado == ACESSO) & ~op_esc & ~reset;
  assign EscMem       = fim & op_esc & ~reset;
  assign Endereco_mem = end_r;
  assign DadoEscr     = dado_r;

`ifdef MEM_BYPASS_EN
  logic                    ult_valido;
  logic [LARGURA_END-1:0]  ult_end;
  logic [LARGURA_DADO-1:0] ult_dado;

  // Record address/data of every store as it retires.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ult_valido <= 1'b0;
      ult_end    <= '0;
      ult_dado   <= '0;
    end else if (fim && op_esc) begin
      ult_valido <= 1'b1;
      ult_end    <= end_r;
      ult_dado   <= dado_r;
    end
  end

  assign acerto     = eh_ler & ult_valido & (ex_endereco == ult_end);
  assign dado_passa = acerto ? ult_dado : ex_dado;
`else
  assign acerto     = 1'b0;
  assign dado_passa = ex_dado;
`endif

  // Main control: accept in OCIOSO, count down in ACESSO, retire to write-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      cont      <= '0;
      end_r     <= '0;
      dado_r    <= '0;
      rd_r      <= '0;
      op_esc    <= 1'b0;
      wb_valido <= 1'b0;
      wb_dado   <= '0;
      wb_rd     <= '0;
      wb_EscReg <= 1'b0;
    end else begin
      wb_valido <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            if (passa) begin
              wb_valido <= 1'b1;
              wb_dado   <= dado_passa;
              wb_rd     <= ex_rd;
              wb_EscReg <= 1'b1;
            end else begin
              end_r  <= ex_endereco;
              dado_r <= ex_dado;
              rd_r   <= ex_rd;
              op_esc <= eh_esc;
              cont   <= CONT_INI;
              estado <= ACESSO;
            end
          end
        end
        ACESSO: begin
          if (cont == '0) begin
            estado    <= OCIOSO;
            wb_valido <= 1'b1;
            wb_rd     <= rd_r;
            if (op_esc) begin
              wb_dado   <= dado_r;
              wb_EscReg <= 1'b0;
            end else begin
              wb_dado   <= DadoLido;
              wb_EscReg <= 1'b1;
            end
          end else begin
            cont <= cont - 1'b1;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
